cp0_reg: RTL and testbench

Coprocessor-0 register file for the MIPS pipeline: the responder to the execute stage's CP0 read port (`raddr_i` → `data_o`) and the sink for MTC0 writes that retire from write-back. It holds Count/Compare/Status/Cause/EPC/PRId/Config and runs the free-running timer. It latches external and timer interrupt lines and records exception state (EPC, Cause.BD/ExcCode, Status.EXL) for the exception unit in the memory stage.

---
 rtl/cp0_defs.sv | 51 +++++
 rtl/cp0_reg.sv | 125 ++++++++++++
 tb/tb_cp0_reg.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and reset constants used by the CP0 register file.
package cp0_defs;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;
   localparam logic [4:0] CP0_PRID    = 5'd15;
   localparam logic [4:0] CP0_CONFIG  = 5'd16;

   localparam logic [31:0] EXC_INT     = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] EXC_RI      = 32'h0000_000A;
   localparam logic [31:0] EXC_OV      = 32'h0000_000C;
   localparam logic [31:0] EXC_TRAP    = 32'h0000_000D;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

   localparam logic [4:0] EXCCODE_INT     = 5'h00;
   localparam logic [4:0] EXCCODE_SYSCALL = 5'h08;
   localparam logic [4:0] EXCCODE_RI      = 5'h0A;
   localparam logic [4:0] EXCCODE_OV      = 5'h0C;
   localparam logic [4:0] EXCCODE_TRAP    = 5'h0D;

   localparam int STATUS_EXL   = 1;
   localparam int CAUSE_BD     = 31;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_IP_LO  = 8;
   localparam int CAUSE_HW_LO  = 10;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_EXC_LO = 2;

   // Software-writable Cause bits: IV, WP and the two software IP bits.
   localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

   localparam logic [31:0] PRID_DEF       = 32'h004C_0102;
   localparam logic [31:0] CONFIG_DEF_RST = 32'h0000_8000;
   localparam logic [31:0] STATUS_DEF_RST = 32'h1000_0000;

   function automatic logic [4:0] exc_code(input logic [31:0] excepttype);
      case (excepttype)
         EXC_SYSCALL: exc_code = EXCCODE_SYSCALL;
         EXC_RI:      exc_code = EXCCODE_RI;
         EXC_OV:      exc_code = EXCCODE_OV;
         EXC_TRAP:    exc_code = EXCCODE_TRAP;
         default:     exc_code = EXCCODE_INT;
      endcase
   endfunction

endpackage

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: MTC0 sink, MFC0 read port, free-running timer,
// interrupt latching and exception state capture.
module cp0_reg
   import cp0_defs::*;
#(
   parameter logic [31:0] PRID_VAL   = PRID_DEF,
   parameter logic [31:0] CONFIG_RST = CONFIG_DEF_RST,
   parameter logic [31:0] STATUS_RST = STATUS_DEF_RST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  raddr_i,
   output logic [31:0] data_o,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] config_o,
   output logic [31:0] prid_o,
   output logic        timer_int_o
);

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [31:0] status_q, status_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic        timer_q, timer_d;

   always_comb begin
      count_d   = count_q + 32'd1;
      compare_d = compare_q;
      status_d  = status_q;
      cause_d   = cause_q;
      epc_d     = epc_q;
      timer_d   = timer_q;

      if (compare_q != 32'd0 && count_q == compare_q) timer_d = 1'b1;

      if (excepttype_i == 32'd0) begin
         if (we_i) begin
            case (waddr_i)
               CP0_COUNT:   count_d = data_i;
               CP0_COMPARE: begin
                  compare_d = data_i;
                  timer_d   = 1'b0;
               end
               CP0_STATUS:  status_d = data_i;
               CP0_CAUSE:   cause_d = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
               CP0_EPC:     epc_d = data_i;
               default:     ;
            endcase
         end
      end else begin
         // A pending MTC0 is squashed along with the excepting instruction.
         case (excepttype_i)
            EXC_INT, EXC_SYSCALL, EXC_RI, EXC_OV, EXC_TRAP: begin
               if (!status_q[STATUS_EXL]) begin
                  epc_d = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                            : current_inst_addr_i;
                  cause_d[CAUSE_BD] = is_in_delayslot_i;
               end
               status_d[STATUS_EXL] = 1'b1;
               cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code(excepttype_i);
            end
            EXC_ERET: status_d[STATUS_EXL] = 1'b0;
            default:  ;
         endcase
      end

      cause_d[CAUSE_IP_HI:CAUSE_HW_LO] = int_i;
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the same pre-edge values computed in the always_comb above.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         status_q  <= STATUS_RST;
         cause_q   <= 32'd0;
         epc_q     <= 32'd0;
         timer_q   <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         status_q  <= status_d;
         cause_q   <= cause_d;
         epc_q     <= epc_d;
         timer_q   <= timer_d;
      end
   end

   // No write bypass: execute forwards MTC0 results itself.
   always_comb begin
      case (raddr_i)
         CP0_COUNT:   data_o = count_q;
         CP0_COMPARE: data_o = compare_q;
         CP0_STATUS:  data_o = status_q;
         CP0_CAUSE:   data_o = cause_q;
         CP0_EPC:     data_o = epc_q;
         CP0_PRID:    data_o = PRID_VAL;
         CP0_CONFIG:  data_o = CONFIG_RST;
         default:     data_o = 32'd0;
      endcase
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign status_o    = status_q;
   assign cause_o     = cause_q;
   assign epc_o       = epc_q;
   assign config_o    = CONFIG_RST;
   assign prid_o      = PRID_VAL;
   assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: expectations are queued after each edge and
// drained against the DUT outputs one time unit later.
module tb_cp0_reg;
   import cp0_defs::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] data_i;
   logic [4:0]  raddr_i;
   logic [31:0] data_o;
   logic [5:0]  int_i;
   logic [31:0] excepttype_i;
   logic [31:0] current_inst_addr_i;
   logic        is_in_delayslot_i;
   logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
   logic        timer_int_o;

   always #5 clk = ~clk;

   cp0_reg dut (
      .clk                 (clk),
      .rst                 (rst),
      .we_i                (we_i),
      .waddr_i             (waddr_i),
      .data_i              (data_i),
      .raddr_i             (raddr_i),
      .data_o              (data_o),
      .int_i               (int_i),
      .excepttype_i        (excepttype_i),
      .current_inst_addr_i (current_inst_addr_i),
      .is_in_delayslot_i   (is_in_delayslot_i),
      .count_o             (count_o),
      .compare_o           (compare_o),
      .status_o            (status_o),
      .cause_o             (cause_o),
      .epc_o               (epc_o),
      .config_o            (config_o),
      .prid_o              (prid_o),
      .timer_int_o         (timer_int_o)
   );

   typedef enum logic [3:0] {
      S_COUNT, S_COMPARE, S_STATUS, S_CAUSE, S_EPC, S_CONFIG, S_PRID, S_DATA, S_TIMER
   } sel_e;

   typedef struct packed {
      logic [7:0]  step;
      sel_e        sel;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          step_no = 0;
   logic [31:0] cnt = 32'd0;
   logic [31:0] c;

   function automatic logic [31:0] observe(input sel_e s);
      case (s)
         S_COUNT:   observe = count_o;
         S_COMPARE: observe = compare_o;
         S_STATUS:  observe = status_o;
         S_CAUSE:   observe = cause_o;
         S_EPC:     observe = epc_o;
         S_CONFIG:  observe = config_o;
         S_PRID:    observe = prid_o;
         S_DATA:    observe = data_o;
         default:   observe = {31'd0, timer_int_o};
      endcase
   endfunction

   task automatic push(input sel_e s, input logic [31:0] v);
      exp_t e;
      e.step = step_no[7:0];
      e.sel  = s;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] o;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         o = observe(e.sel);
         total++;
         assert (o === e.exp) else begin
            bad++;
            $error("FAIL step%0d %s observed=%h expected=%h", e.step, e.sel.name(), o, e.exp);
         end
      end
   endtask

   task automatic read_chk(input logic [4:0] a, input logic [31:0] v);
      raddr_i = a;
      #1;
      push(S_DATA, v);
      drain();
   endtask

   // Count reference: reset clears, an unsquashed MTC0 loads, otherwise +1.
   task automatic tick();
      if (rst) cnt = 32'd0;
      else if (we_i && waddr_i == CP0_COUNT && excepttype_i == 32'd0) cnt = data_i;
      else cnt = cnt + 32'd1;
      @(posedge clk);
      #1;
      step_no++;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we_i    = 1'b1;
      waddr_i = a;
      data_i  = d;
   endtask

   task automatic idle();
      we_i         = 1'b0;
      excepttype_i = 32'd0;
   endtask

   initial begin
      rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; raddr_i = 5'd0;
      int_i = 6'd0; excepttype_i = 32'd0; current_inst_addr_i = 32'd0;
      is_in_delayslot_i = 1'b0;

      // Reset state, then five idle cycles.
      tick(); tick();
      push(S_COUNT, 32'd0); push(S_COMPARE, 32'd0); push(S_STATUS, 32'h1000_0000);
      push(S_CAUSE, 32'd0); push(S_EPC, 32'd0); push(S_TIMER, 32'd0);
      push(S_CONFIG, 32'h0000_8000); push(S_PRID, 32'h004C_0102);
      drain();
      rst = 1'b0;
      repeat (5) tick();
      push(S_COUNT, 32'd5); drain();
      read_chk(5'd20, 32'd0);
      read_chk(CP0_COUNT, 32'd5);

      // Mid-run reset discards a pending Count write.
      rst = 1'b1; wr(CP0_COUNT, 32'h55);
      tick();
      push(S_COUNT, 32'd0); drain();
      rst = 1'b0; idle();
      repeat (3) tick();
      push(S_COUNT, 32'd3); drain();

      // Timer: Compare=10 written at Count=3.
      wr(CP0_COMPARE, 32'd10);
      tick(); idle();
      push(S_COMPARE, 32'd10); push(S_COUNT, 32'd4); drain();
      repeat (6) tick();
      push(S_COUNT, 32'd10); push(S_TIMER, 32'd0); drain();
      tick();
      push(S_TIMER, 32'd1); drain();
      repeat (2) tick();
      push(S_TIMER, 32'd1); drain();
      wr(CP0_COMPARE, 32'd0);
      tick(); idle();
      push(S_TIMER, 32'd0); push(S_COMPARE, 32'd0); drain();

      // Compare write in the matching cycle: the clear wins.
      c = cnt + 32'd2;
      wr(CP0_COMPARE, c);
      tick(); idle();
      tick();
      push(S_COUNT, c); drain();
      wr(CP0_COMPARE, c);
      tick(); idle();
      push(S_TIMER, 32'd0); drain();
      tick();
      push(S_TIMER, 32'd0); drain();

      // Count wrap.
      wr(CP0_COUNT, 32'hFFFF_FFFE);
      tick(); idle();
      push(S_COUNT, 32'hFFFF_FFFE); drain();
      tick(); read_chk(CP0_COUNT, 32'hFFFF_FFFF);
      tick(); read_chk(CP0_COUNT, 32'h0000_0000);
      tick(); read_chk(CP0_COUNT, 32'h0000_0001);
      push(S_COUNT, cnt); drain();

      // Syscall in a delay slot, then a nested overflow, an unknown code, ERET.
      excepttype_i = EXC_SYSCALL; current_inst_addr_i = 32'hBFC0_0100; is_in_delayslot_i = 1'b1;
      tick();
      push(S_EPC, 32'hBFC0_00FC); push(S_CAUSE, 32'h8000_0020); push(S_STATUS, 32'h1000_0002);
      drain();
      excepttype_i = EXC_OV; current_inst_addr_i = 32'h1234_5678; is_in_delayslot_i = 1'b0;
      tick();
      push(S_EPC, 32'hBFC0_00FC); push(S_CAUSE, 32'h8000_0030); push(S_STATUS, 32'h1000_0002);
      drain();
      excepttype_i = 32'h0000_0005;
      tick();
      push(S_EPC, 32'hBFC0_00FC); push(S_CAUSE, 32'h8000_0030); push(S_STATUS, 32'h1000_0002);
      drain();
      excepttype_i = EXC_ERET;
      tick(); idle();
      push(S_STATUS, 32'h1000_0000); push(S_CAUSE, 32'h8000_0030); push(S_EPC, 32'hBFC0_00FC);
      drain();

      // Read-only PRId / Config.
      wr(CP0_PRID, 32'd0);
      tick();
      wr(CP0_CONFIG, 32'd0);
      tick(); idle();
      push(S_PRID, 32'h004C_0102); push(S_CONFIG, 32'h0000_8000); drain();
      read_chk(CP0_PRID, 32'h004C_0102);
      read_chk(CP0_CONFIG, 32'h0000_8000);

      // Status write; same-cycle read returns the old value.
      wr(CP0_STATUS, 32'h0000_FF01);
      read_chk(CP0_STATUS, 32'h1000_0000);
      tick(); idle();
      read_chk(CP0_STATUS, 32'h0000_FF01);

      // Cause masking and interrupt latching from a clean reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      int_i = 6'b000001; wr(CP0_CAUSE, 32'hFFFF_FFFF);
      tick(); idle();
      push(S_CAUSE, 32'h00C0_0700); drain();
      int_i = 6'b100000;
      tick();
      push(S_CAUSE, 32'h00C0_8300); drain();
      int_i = 6'b000000;
      tick();
      push(S_CAUSE, 32'h00C0_0300); drain();

      // MTC0 to EPC squashed by an interrupt in the same cycle.
      wr(CP0_EPC, 32'hDEAD_BEEF);
      excepttype_i = EXC_INT; current_inst_addr_i = 32'h8000_1000; is_in_delayslot_i = 1'b0;
      read_chk(CP0_EPC, 32'd0);
      tick(); idle();
      push(S_EPC, 32'h8000_1000); push(S_STATUS, 32'h1000_0002); push(S_CAUSE, 32'h00C0_0300);
      drain();

      // Count write squashed by ERET; the increment still happens.
      wr(CP0_COUNT, 32'h100); excepttype_i = EXC_ERET;
      tick(); idle();
      push(S_COUNT, cnt); push(S_STATUS, 32'h1000_0000); drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
